conv_engine: RTL
================

CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter SHIFT9, default 4: right-shift applied to every 3x3 accumulator before saturation.
REQ-002 SHALL have parameter SHIFT4, default 2: right-shift applied to every 2x2 accumulator before saturation.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset; asserting it resets the block immediately.
REQ-006 pix_data  input  8  unsigned pixel; 16 pixels per image, raster order (row 0 col 0 first).
REQ-007 pix_valid  input  1  pix_data is valid this cycle.
REQ-008 pix_ready  output  1  block accepts a pixel this cycle; transfer occurs when pix_valid & pix_ready.
REQ-009 k9  input  36  3x3 kernel, 9 unsigned 4-bit taps; tap t = 3*row+col at k9[4t+3:4t].
REQ-010 k4  input  16  2x2 kernel, 4 unsigned 4-bit taps; tap t = 2*row+col at k4[4t+3:4t].
REQ-011 c9_11, c9_12, c9_21, c9_22  output  8 each  3x3 valid-convolution results (row, col).
REQ-012 c4_11, c4_12, c4_21, c4_22  output  8 each  2x2 stride-2 convolution results (row, col).
REQ-013 busy  output  1  high while the block is in CALC9 or CALC4.
REQ-014 done  output  1  one-cycle pulse; all eight results were updated on the same edge.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CALC9, CALC4, DONE.
REQ-016 pix_ready SHALL be 1 in IDLE and LOAD, and 0 in CALC9, CALC4 and DONE.
REQ-017 IDLE -> LOAD on the first accepted pixel; the internal pixel counter SHALL be 0..15.
REQ-018 Gaps in pix_valid SHALL stall the load without losing pixels or advancing the counter.
REQ-019 On the edge that accepts pixel 15, the block SHALL snapshot k9 and k4 and enter CALC9.
REQ-020 Kernel input changes after the snapshot SHALL NOT affect the current image.
REQ-021 CALC9 SHALL perform one multiply-accumulate per cycle: 4 outputs x 9 taps = exactly 36 cycles, then go to CALC4.
REQ-022 c9_rc SHALL equal sum over i,j in 0..2 of p[r-1+i][c-1+j]*k9[3i+j], with r,c in 1..2.
REQ-023 CALC4 SHALL take exactly 16 cycles (4 outputs x 4 taps), then go to DONE.
REQ-024 c4_rc SHALL equal sum over i,j in 0..1 of p[2(r-1)+i][2(c-1)+j]*k4[2i+j].
REQ-025 Accumulators SHALL be 16-bit unsigned; the maxima 34425 (3x3) and 15300 (2x2) do not overflow.
REQ-026 Each result SHALL be (acc >> SHIFTn), saturated to 255 if it exceeds 255.
REQ-027 All eight output registers SHALL load simultaneously on the edge entering DONE; no partial update is visible.
REQ-028 done SHALL be 1 for exactly the single DONE cycle, which is cycle 53 after the last-pixel acceptance edge.
REQ-029 DONE -> IDLE unconditionally.
REQ-030 Outputs SHALL hold their values until the next DONE; loading a new image SHALL NOT disturb them.
REQ-031 pix_valid during CALC9, CALC4 or DONE SHALL be ignored; no pixel is consumed.

Reset
REQ-032 While resetn = 0: state = IDLE, pixel counter = 0, accumulators = 0, all eight results = 0, busy = 0, done = 0.
REQ-033 Reset asserted mid-LOAD or mid-CALC SHALL discard the partial image; outputs read 0 and no done pulse occurs.
REQ-034 After reset release, pix_ready SHALL be 1 in the first cycle.

Verification
REQ-035 All pixels = 16, all k9 taps = 1, all k4 taps = 1, default parameters -> done at cycle 53; every c9 = 9; every c4 = 16.
REQ-036 All pixels = 255, all taps = 15 -> all eight outputs = 255 (saturation).
REQ-037 Ramp p = 0..15, k4 all 1, SHIFT4 = 2 -> c4_11 = 2, c4_12 = 4, c4_21 = 10, c4_22 = 12.
REQ-038 Ramp p = 0..15, k9 center tap only = 1, SHIFT9 = 0 -> c9_11 = 5, c9_12 = 6, c9_21 = 9, c9_22 = 10.
REQ-039 Random pix_valid gaps plus pix_valid held high during CALC -> results identical to the gap-free run; pix_ready = 0 throughout busy.
REQ-040 resetn pulsed low at CALC9 cycle 20 -> outputs 0, no done; a full reload afterwards produces the correct results.

Source files
------------

// File: rtl/conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_engine
// Description : Loads a 4x4 image of 8-bit pixels, then computes the four
//               3x3 "valid" convolution results and the four 2x2 stride-2
//               convolution results with a single multiply-accumulate unit.
//               Each result is right-shifted and saturated to 8 bits. All
//               eight outputs update together on the edge that enters DONE.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   pix_data   in   8   unsigned pixel, raster order
//   pix_valid  in   1   pix_data valid
//   pix_ready  out  1   pixel accepted when pix_valid & pix_ready
//   k9         in  36   3x3 kernel, tap t = 3*row+col at [4t+3:4t]
//   k4         in  16   2x2 kernel, tap t = 2*row+col at [4t+3:4t]
//   c9_rc      out  8   3x3 results, r,c in 1..2
//   c4_rc      out  8   2x2 stride-2 results, r,c in 1..2
//   busy       out  1   high during CALC9 / CALC4
//   done       out  1   single-cycle pulse when results update
// ============================================================================
module conv_engine #(
   parameter int SHIFT9 = 4,
   parameter int SHIFT4 = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [35:0] k9,
   input  logic [15:0] k4,
   output logic [7:0]  c9_11,
   output logic [7:0]  c9_12,
   output logic [7:0]  c9_21,
   output logic [7:0]  c9_22,
   output logic [7:0]  c4_11,
   output logic [7:0]  c4_12,
   output logic [7:0]  c4_21,
   output logic [7:0]  c4_22,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CALC9 = 3'd2,
      S_CALC4 = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_pix [16];
   logic [3:0]  r_pix_cnt;
   logic [35:0] r_k9;
   logic [15:0] r_k4;
   // Tap row/column and output index of the current MAC step
   logic [1:0]  r_ti;
   logic [1:0]  r_tj;
   logic [1:0]  r_oi;
   logic [15:0] r_acc [8];
   logic [7:0]  r_res [8];

   logic        w_accept;
   logic        w_mac_en;
   logic [1:0]  w_tap_max;
   logic        w_last_tap;
   logic        w_phase_end;
   logic        w_load_res;
   logic [1:0]  w_row;
   logic [1:0]  w_col;
   logic [3:0]  w_tap9;
   logic [3:0]  w_coef;
   logic [2:0]  w_sel;
   logic [7:0]  w_pix;
   logic [11:0] w_prod;
   logic [15:0] w_sum [8];
   logic [7:0]  w_res_next [8];

   assign pix_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign busy      = (r_state == S_CALC9) || (r_state == S_CALC4);
   assign done      = (r_state == S_DONE);
   assign w_accept  = pix_valid & pix_ready;
   assign w_mac_en  = busy;

   // Operand selection for the current MAC step
   always_comb begin
      w_tap_max = (r_state == S_CALC4) ? 2'd1 : 2'd2;
      w_tap9    = ({2'b00, r_ti} * 4'd3) + {2'b00, r_tj};
      if (r_state == S_CALC4) begin
         // Stride-2 window: top-left corner at (2*out_row, 2*out_col)
         w_row  = {r_oi[1], r_ti[0]};
         w_col  = {r_oi[0], r_tj[0]};
         w_coef = r_k4[{r_ti[0], r_tj[0], 2'b00} +: 4];
         w_sel  = {1'b1, r_oi};
      end else begin
         w_row  = {1'b0, r_oi[1]} + r_ti;
         w_col  = {1'b0, r_oi[0]} + r_tj;
         w_coef = r_k9[{w_tap9, 2'b00} +: 4];
         w_sel  = {1'b0, r_oi};
      end
      w_last_tap  = (r_ti == w_tap_max) && (r_tj == w_tap_max);
      w_phase_end = w_last_tap && (r_oi == 2'd3);
      w_pix       = r_pix[{w_row, w_col}];
      w_prod      = {4'b0000, w_pix} * {8'b0000_0000, w_coef};
      w_load_res  = (r_state == S_CALC4) && w_phase_end;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_LOAD;
         S_LOAD:  if (w_accept && (r_pix_cnt == 4'd15)) w_state_next = S_CALC9;
         S_CALC9: if (w_phase_end) w_state_next = S_CALC4;
         S_CALC4: if (w_phase_end) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Accumulator update, scaling and saturation. The sum includes the MAC
   // being performed this cycle so the final tap of c4_22 lands directly in
   // the result registers on the edge entering DONE.
   for (genvar g = 0; g < 8; g++) begin : g_res
      localparam int c_shift = (g < 4) ? SHIFT9 : SHIFT4;
      logic [15:0] w_shifted;
      assign w_sum[g]      = r_acc[g] + ((w_sel == 3'(g)) ? {4'b0000, w_prod} : 16'd0);
      assign w_shifted     = w_sum[g] >> c_shift;
      assign w_res_next[g] = (|w_shifted[15:8]) ? 8'hFF : w_shifted[7:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_pix_cnt <= '0;
         r_k9      <= '0;
         r_k4      <= '0;
         r_ti      <= '0;
         r_tj      <= '0;
         r_oi      <= '0;
         for (int i = 0; i < 16; i++) r_pix[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            r_acc[i] <= '0;
            r_res[i] <= '0;
         end
      end else begin
         r_state <= w_state_next;

         if (w_accept) begin
            r_pix[r_pix_cnt] <= pix_data;
            r_pix_cnt        <= r_pix_cnt + 4'd1;
            if (r_pix_cnt == 4'd15) begin
               // Kernel snapshot: later input changes do not affect this image
               r_k9 <= k9;
               r_k4 <= k4;
               for (int i = 0; i < 8; i++) r_acc[i] <= '0;
            end
         end

         if (w_mac_en) begin
            r_acc[w_sel] <= w_sum[w_sel];
            if (r_tj == w_tap_max) begin
               r_tj <= '0;
               if (r_ti == w_tap_max) begin
                  r_ti <= '0;
                  r_oi <= r_oi + 2'd1;
               end else begin
                  r_ti <= r_ti + 2'd1;
               end
            end else begin
               r_tj <= r_tj + 2'd1;
            end
         end else begin
            r_ti <= '0;
            r_tj <= '0;
            r_oi <= '0;
         end

         if (w_load_res) begin
            for (int i = 0; i < 8; i++) r_res[i] <= w_res_next[i];
         end
      end
   end

   assign c9_11 = r_res[0];
   assign c9_12 = r_res[1];
   assign c9_21 = r_res[2];
   assign c9_22 = r_res[3];
   assign c4_11 = r_res[4];
   assign c4_12 = r_res[5];
   assign c4_21 = r_res[6];
   assign c4_22 = r_res[7];

endmodule
`default_nettype wire
